// File: rtl/fp_mul_pipe.sv
`default_nettype none
// ============================================================================
// Module   : fp_mul_pipe
// Purpose  : Three-stage pipelined floating-point multiplier for a generic
//            {sign, biased exponent, mantissa} format. It rounds to nearest
//            even, flushes subnormal inputs and tiny results to zero, and
//            produces a canonical quiet NaN. Each stage has valid/ready flow
//            control.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk_i        in   1   clock, rising edge
//   rst_i        in   1   asynchronous active-high reset
//   in_valid_i   in   1   operand pair present
//   in_ready_o   out  1   operands accepted this cycle
//   a_i, b_i     in   W   operands, W = 1+EXP_W+MAN_W
//   neg_i        in   1   return -(a*b)
//   out_valid_o  out  1   result present
//   out_ready_i  in   1   consumer takes result
//   result_o     out  W   packed product
//   flags_o      out  4   {invalid, overflow, underflow, inexact}
// ============================================================================
module fp_mul_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [EXP_W+MAN_W:0] a_i,
  input  logic [EXP_W+MAN_W:0] b_i,
  input  logic                 neg_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [EXP_W+MAN_W:0] result_o,
  output logic [3:0]           flags_o
);

  localparam int c_w      = 1 + EXP_W + MAN_W;
  localparam int c_sig_w  = MAN_W + 1;
  localparam int c_prod_w = 2 * c_sig_w;
  localparam int c_e_w    = EXP_W + 2;

  localparam logic [c_e_w-1:0] c_bias     = c_e_w'((1 << (EXP_W - 1)) - 1);
  localparam logic [c_e_w-1:0] c_exp_max  = c_e_w'((1 << EXP_W) - 1);
  localparam logic [MAN_W-1:0] c_qnan_man = MAN_W'(1) << (MAN_W - 1);

  // Operand-pair classes carried down the pipe
  localparam logic [1:0] c_cls_norm = 2'd0;
  localparam logic [1:0] c_cls_zero = 2'd1;
  localparam logic [1:0] c_cls_inf  = 2'd2;
  localparam logic [1:0] c_cls_nan  = 2'd3;

  // --------------------------------------------------------------------------
  // Stage registers
  // --------------------------------------------------------------------------
  logic                s1_valid_q, s1_valid_d;
  logic                s1_sign_q, s1_sign_d;
  logic [1:0]          s1_cls_q, s1_cls_d;
  logic [c_prod_w-1:0] s1_prod_q, s1_prod_d;
  logic [c_e_w-1:0]    s1_exp_q, s1_exp_d;

  logic                s2_valid_q, s2_valid_d;
  logic                s2_sign_q, s2_sign_d;
  logic [1:0]          s2_cls_q, s2_cls_d;
  logic [MAN_W-1:0]    s2_man_q, s2_man_d;
  logic [c_e_w-1:0]    s2_exp_q, s2_exp_d;
  logic                s2_inexact_q, s2_inexact_d;

  logic                s3_valid_q, s3_valid_d;
  logic [c_w-1:0]      s3_result_q, s3_result_d;
  logic [3:0]          s3_flags_q, s3_flags_d;

  // --------------------------------------------------------------------------
  // Flow control: each stage is free when empty or when it empties this cycle
  // --------------------------------------------------------------------------
  logic w_s3_free, w_s2_adv, w_s2_free, w_s1_adv, w_accept;

  always_comb begin
    w_s3_free  = ~s3_valid_q | out_ready_i;
    w_s2_adv   = s2_valid_q & w_s3_free;
    w_s2_free  = ~s2_valid_q | w_s2_adv;
    w_s1_adv   = s1_valid_q & w_s2_free;
    in_ready_o = ~s1_valid_q | w_s1_adv;
    w_accept   = in_valid_i & in_ready_o;
  end

  // --------------------------------------------------------------------------
  // S1: classify operands, multiply significands, sum exponents
  // --------------------------------------------------------------------------
  logic [EXP_W-1:0] w_a_exp, w_b_exp;
  logic [MAN_W-1:0] w_a_man, w_b_man;
  logic             w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;

  always_comb begin
    w_a_exp  = a_i[c_w-2:MAN_W];
    w_b_exp  = b_i[c_w-2:MAN_W];
    w_a_man  = a_i[MAN_W-1:0];
    w_b_man  = b_i[MAN_W-1:0];
    // Zero exponent covers subnormals too: they are treated as zero
    w_a_zero = ~|w_a_exp;
    w_b_zero = ~|w_b_exp;
    w_a_inf  = (&w_a_exp) & ~|w_a_man;
    w_b_inf  = (&w_b_exp) & ~|w_b_man;
    w_a_nan  = (&w_a_exp) & (|w_a_man);
    w_b_nan  = (&w_b_exp) & (|w_b_man);

    s1_valid_d = w_accept | (s1_valid_q & ~w_s1_adv);
    s1_sign_d  = s1_sign_q;
    s1_cls_d   = s1_cls_q;
    s1_prod_d  = s1_prod_q;
    s1_exp_d   = s1_exp_q;

    if (w_accept) begin
      s1_sign_d = a_i[c_w-1] ^ b_i[c_w-1] ^ neg_i;
      if (w_a_nan | w_b_nan | (w_a_inf & w_b_zero) | (w_b_inf & w_a_zero)) begin
        s1_cls_d = c_cls_nan;
      end else if (w_a_inf | w_b_inf) begin
        s1_cls_d = c_cls_inf;
      end else if (w_a_zero | w_b_zero) begin
        s1_cls_d = c_cls_zero;
      end else begin
        s1_cls_d = c_cls_norm;
      end
      s1_prod_d = {{c_sig_w{1'b0}}, 1'b1, w_a_man} * {{c_sig_w{1'b0}}, 1'b1, w_b_man};
      // Two's complement at EXP_W+2 bits: holds every sum of normal exponents
      s1_exp_d  = {2'b00, w_a_exp} + {2'b00, w_b_exp} - c_bias;
    end
  end

  // --------------------------------------------------------------------------
  // S2: normalise product to [1,2), round to nearest even
  // --------------------------------------------------------------------------
  logic                w_top, w_guard, w_sticky, w_round_up, w_carry;
  logic [c_prod_w-1:0] w_norm;
  logic [c_sig_w-1:0]  w_kept;
  logic [c_sig_w:0]    w_rounded;

  always_comb begin
    w_top      = s1_prod_q[c_prod_w-1];
    // Left-align the leading one; bits shifted in are zero so sticky is unaffected
    w_norm     = w_top ? s1_prod_q : (s1_prod_q << 1);
    w_kept     = w_norm[c_prod_w-1 -: c_sig_w];
    w_guard    = w_norm[c_prod_w-1-c_sig_w];
    w_sticky   = |w_norm[c_prod_w-2-c_sig_w:0];
    w_round_up = w_guard & (w_sticky | w_kept[0]);
    w_rounded  = {1'b0, w_kept} + {{c_sig_w{1'b0}}, w_round_up};
    // Carry-out means 1.11..1 rounded up to 10.00..0
    w_carry    = w_rounded[c_sig_w];

    s2_valid_d   = w_s1_adv | (s2_valid_q & ~w_s2_adv);
    s2_sign_d    = s2_sign_q;
    s2_cls_d     = s2_cls_q;
    s2_man_d     = s2_man_q;
    s2_exp_d     = s2_exp_q;
    s2_inexact_d = s2_inexact_q;

    if (w_s1_adv) begin
      s2_sign_d    = s1_sign_q;
      s2_cls_d     = s1_cls_q;
      s2_man_d     = w_carry ? w_rounded[MAN_W:1] : w_rounded[MAN_W-1:0];
      s2_exp_d     = s1_exp_q + c_e_w'(w_top) + c_e_w'(w_carry);
      s2_inexact_d = w_guard | w_sticky;
    end
  end

  // --------------------------------------------------------------------------
  // S3: range check on the rounded exponent, pack, flags
  // --------------------------------------------------------------------------
  logic w_exp_high, w_exp_low;

  always_comb begin
    w_exp_high = ~s2_exp_q[c_e_w-1] & (s2_exp_q >= c_exp_max);
    w_exp_low  = s2_exp_q[c_e_w-1] | (s2_exp_q == '0);

    s3_valid_d  = w_s2_adv | (s3_valid_q & ~out_ready_i);
    s3_result_d = s3_result_q;
    s3_flags_d  = s3_flags_q;

    if (w_s2_adv) begin
      case (s2_cls_q)
        c_cls_nan: begin
          s3_result_d = {1'b0, {EXP_W{1'b1}}, c_qnan_man};
          s3_flags_d  = 4'b1000;
        end
        c_cls_inf: begin
          s3_result_d = {s2_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          s3_flags_d  = 4'b0000;
        end
        c_cls_zero: begin
          s3_result_d = {s2_sign_q, {(c_w-1){1'b0}}};
          s3_flags_d  = 4'b0000;
        end
        default: begin
          if (w_exp_high) begin
            s3_result_d = {s2_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            s3_flags_d  = 4'b0101;
          end else if (w_exp_low) begin
            s3_result_d = {s2_sign_q, {(c_w-1){1'b0}}};
            s3_flags_d  = 4'b0011;
          end else begin
            s3_result_d = {s2_sign_q, s2_exp_q[EXP_W-1:0], s2_man_q};
            s3_flags_d  = {3'b000, s2_inexact_q};
          end
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_valid_q   <= 1'b0;
      s1_sign_q    <= 1'b0;
      s1_cls_q     <= c_cls_zero;
      s1_prod_q    <= '0;
      s1_exp_q     <= '0;
      s2_valid_q   <= 1'b0;
      s2_sign_q    <= 1'b0;
      s2_cls_q     <= c_cls_zero;
      s2_man_q     <= '0;
      s2_exp_q     <= '0;
      s2_inexact_q <= 1'b0;
      s3_valid_q   <= 1'b0;
      s3_result_q  <= '0;
      s3_flags_q   <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_sign_q    <= s1_sign_d;
      s1_cls_q     <= s1_cls_d;
      s1_prod_q    <= s1_prod_d;
      s1_exp_q     <= s1_exp_d;
      s2_valid_q   <= s2_valid_d;
      s2_sign_q    <= s2_sign_d;
      s2_cls_q     <= s2_cls_d;
      s2_man_q     <= s2_man_d;
      s2_exp_q     <= s2_exp_d;
      s2_inexact_q <= s2_inexact_d;
      s3_valid_q   <= s3_valid_d;
      s3_result_q  <= s3_result_d;
      s3_flags_q   <= s3_flags_d;
    end
  end

  assign out_valid_o = s3_valid_q;
  assign result_o    = s3_result_q;
  assign flags_o     = s3_flags_q;

endmodule
`default_nettype wire
